// File: rtl/ch375_seq.sv
// ch375_seq: hardware command sequencer in front of the ch375b serial driver.
// A CPU writes the transmit bytes, then one CTRL word. The sequencer sends the
// command byte and 0-8 data bytes, optionally waits for nint, then collects
// 0-8 response bytes. It raises a one-cycle irq when the transaction ends.
//
// Handshake with ch375b: each bus write is a single-cycle m_we pulse. It is
// followed by one SETTLE cycle with m_we low, so the ch375b flag read on the
// next poll already reflects that write. Readiness is seen only through the
// m_spo[24] flag of the address being polled.
module ch375_seq #(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic [2:0]  m_a,
  output logic [31:0] m_d,
  output logic        m_we,
  input  logic [31:0] m_spo
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CLR_RX, TX_POLL, TX_WRITE, SETTLE,
    INT_WAIT, RX_POLL, RX_READ, RX_ACK, FINISH
  } state_t;

  state_t       state, state_next;
  logic [7:0]   cmd;
  logic [3:0]   tx_len, rx_len;
  logic [3:0]   tx_cnt, rx_cnt;
  logic [3:0]   tx_idx;
  logic         wait_int;
  logic         busy, done, err;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]   txbuf [8];
  logic [7:0]   rxbuf [8];
  logic         start, clr, flag, waiting, tmo_hit, set_err;
  logic [2:0]   nxt_m_a;
  logic [31:0]  nxt_m_d;
  logic         nxt_m_we;
  logic         unused_bits;

  // Lengths above 8 saturate to the buffer depth.
  function automatic logic [3:0] clamp8(input logic [3:0] v);
    return (v > 4'd8) ? 4'd8 : v;
  endfunction

  assign start   = we && (a == 4'd0) && (state == IDLE);
  assign clr     = we && (a == 4'd1);
  assign flag    = m_spo[24];
  assign waiting = (state == TX_POLL) || (state == INT_WAIT) || (state == RX_POLL);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
  assign busy    = (state != IDLE) && (state != FINISH);
  assign irq     = (state == FINISH);
  assign tx_idx  = tx_cnt - 4'd1;
  assign unused_bits = ^{d[14:0], m_spo[23:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a wait that expires goes straight to FINISH with an error.
  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      IDLE:     if (start) state_next = CLR_RX;
      CLR_RX:   state_next = TX_POLL;
      TX_POLL: begin
        if (flag)         state_next = TX_WRITE;
        else if (tmo_hit) begin state_next = FINISH; set_err = 1'b1; end
      end
      TX_WRITE: state_next = SETTLE;
      // tx_cnt already counts the byte just written (command included).
      SETTLE: begin
        if (tx_cnt != tx_len + 4'd1) state_next = TX_POLL;
        else if (wait_int)           state_next = INT_WAIT;
        else if (rx_len == 4'd0)     state_next = FINISH;
        else                         state_next = RX_POLL;
      end
      INT_WAIT: begin
        if (!flag)        state_next = (rx_len == 4'd0) ? FINISH : RX_POLL;
        else if (tmo_hit) begin state_next = FINISH; set_err = 1'b1; end
      end
      RX_POLL: begin
        if (flag)         state_next = RX_READ;
        else if (tmo_hit) begin state_next = FINISH; set_err = 1'b1; end
      end
      RX_READ:  state_next = RX_ACK;
      RX_ACK:   state_next = (rx_cnt == rx_len) ? FINISH : RX_POLL;
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Bus outputs for the state being entered; SETTLE and FINISH hold m_a/m_d.
  always_comb begin
    nxt_m_a  = m_a;
    nxt_m_d  = m_d;
    nxt_m_we = 1'b0;
    case (state_next)
      IDLE:     nxt_m_a = 3'd2;
      CLR_RX:   begin nxt_m_a = 3'd1; nxt_m_we = 1'b1; end
      TX_POLL:  nxt_m_a = 3'd2;
      TX_WRITE: begin
        nxt_m_we = 1'b1;
        if (tx_cnt == 4'd0) begin
          nxt_m_a = 3'd0;
          nxt_m_d = {cmd, 24'h0};
        end else begin
          nxt_m_a = 3'd2;
          nxt_m_d = {txbuf[tx_idx[2:0]], 24'h0};
        end
      end
      INT_WAIT: nxt_m_a = 3'd3;
      RX_POLL:  nxt_m_a = 3'd1;
      RX_READ:  nxt_m_a = 3'd0;
      RX_ACK:   begin nxt_m_a = 3'd1; nxt_m_we = 1'b1; end
      default:  ;
    endcase
  end

  // Registered ch375b bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_a  <= 3'd2;
      m_d  <= 32'h0;
      m_we <= 1'b0;
    end else begin
      m_a  <= nxt_m_a;
      m_d  <= nxt_m_d;
      m_we <= nxt_m_we;
    end
  end

  // Transaction fields, byte counters and done/err flags.
  // Entering FINISH wins over a simultaneous clear, and a clear in the FINISH
  // cycle is also dropped so the completion is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      err    <= 1'b0;
      rx_cnt <= 4'd0;
      tx_cnt <= 4'd0;
    end else begin
      if (start) begin
        cmd      <= d[31:24];
        tx_len   <= clamp8(d[23:20]);
        rx_len   <= clamp8(d[19:16]);
        wait_int <= d[15];
        rx_cnt   <= 4'd0;
        tx_cnt   <= 4'd0;
      end
      if (state == TX_WRITE) tx_cnt <= tx_cnt + 4'd1;
      if (state == RX_READ)  rx_cnt <= rx_cnt + 4'd1;
      if (state_next == FINISH && state != FINISH) begin
        done <= 1'b1;
        if (set_err) err <= 1'b1;
      end else if (state != FINISH && (start || clr)) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
    end
  end

  // Byte buffers (not reset): CPU fills txbuf while idle, RX_READ fills rxbuf.
  always_ff @(posedge clk) begin
    if (we && a[3] && !busy) txbuf[a[2:0]] <= d[31:24];
    if (state == RX_READ)    rxbuf[rx_cnt[2:0]] <= m_spo[31:24];
  end

  // Wait timeout: restarts on every state change, counts while polling.
  always_ff @(posedge clk) begin
    if (rst || state_next != state) tmo_cnt <= '0;
    else if (waiting)               tmo_cnt <= tmo_cnt + 1'b1;
  end

  // CPU read mux.
  always_comb begin
    spo = 32'h0;
    if (a == 4'd0)      spo = {busy, done, err, 29'h0};
    else if (a == 4'd1) spo = {4'h0, rx_cnt, 24'h0};
    else if (a[3])      spo = {rxbuf[a[2:0]], 24'h0};
  end

endmodule

// File: tb/tb_ch375_seq.sv
// tb_ch375_seq: directed bench for ch375_seq with a behavioural ch375b model.
module tb_ch375_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;
  logic        irq;
  logic [2:0]  m_a;
  logic [31:0] m_d;
  logic        m_we;
  logic [31:0] m_spo;

  int tests_run = 0;
  int fails     = 0;
  int wr_count  = 0;
  int irq_count = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  ch375_seq #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
    .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_spo(m_spo)
  );

  // ---------------- ch375b model ----------------
  logic       rx_new = 1'b0;
  logic       armed = 1'b0;
  logic       nint = 1'b1;
  logic       tx_stall = 1'b0;
  logic [7:0] rx_byte = 8'h0;
  logic [2:0] tx_busy = 3'd0;
  logic [2:0] rx_wait = 3'd0;
  logic [7:0] rsp_q[$];

  always_comb begin
    m_spo = 32'h0;
    case (m_a)
      3'd0: m_spo = {rx_byte, 24'h0};
      3'd1: m_spo = {7'h0, rx_new, 24'h0};
      3'd2: m_spo = {7'h0, (tx_busy == 3'd0) && !tx_stall, 24'h0};
      3'd3: m_spo = {7'h0, nint, 24'h0};
      default: m_spo = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      rx_new  <= 1'b0;
      armed   <= 1'b0;
      tx_busy <= 3'd0;
      rx_wait <= 3'd0;
    end else begin
      if (m_we && m_a == 3'd1) rx_new <= 1'b0;
      if (m_we && m_a == 3'd0) armed <= 1'b1;
      else if (irq)            armed <= 1'b0;
      if (m_we && m_a != 3'd1) tx_busy <= 3'($urandom_range(0, 3));
      else if (tx_busy != 3'd0) tx_busy <= tx_busy - 3'd1;
      if (!rx_new && armed && rsp_q.size() != 0) begin
        if (rx_wait == 3'd0) begin
          rx_byte <= rsp_q.pop_front();
          rx_new  <= 1'b1;
          rx_wait <= 3'($urandom_range(0, 4));
        end else begin
          rx_wait <= rx_wait - 3'd1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {m_a, byte}; byte is 0 for a=1 writes
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_w(input logic [2:0] addr, input logic [7:0] b);
    exp_q.push_back({addr, b});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_we <= 1'b0;
    end else begin
      if (prev_we) check("idle_after_write", {63'h0, m_we}, 64'h0);
      if (m_we) begin
        wr_count++;
        tests_run++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_write: observed m_a=%0d m_d=%h expected no write", m_a, m_d);
        end
        if (exp_q.size() != 0) begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("m_write", {m_a, (m_a == 3'd1) ? 32'h0 : m_d},
                {e[10:8], (e[10:8] == 3'd1) ? 32'h0 : {e[7:0], 24'h0}});
        end
      end
      if (irq) irq_count++;
      prev_we <= m_we;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data);
    tick();
    a  = addr;
    d  = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] addr, output logic [31:0] data);
    tick();
    a = addr;
    #1;
    data = spo;
  endtask

  function automatic logic [31:0] ctrl(input logic [7:0] c, input logic [3:0] txl,
                                       input logic [3:0] rxl, input logic wi);
    return {c, txl, rxl, wi, 15'h0};
  endfunction

  task automatic wait_irq();
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!irq && cyc < 2000);
    check("irq_seen", {63'h0, irq}, 64'h1);
  endtask

  task automatic wait_writes(input int target);
    int cyc;
    cyc = 0;
    while (wr_count < target && cyc < 500) begin
      tick();
      cyc++;
    end
    check("write_count", wr_count, target);
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    cpu_read(addr, v);
    check(tag, v, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int i0, w0, k, bad;
    rst = 1'b1; a = 4'd0; d = 32'h0; we = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_m_a", m_a, 3'd2);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_d", m_d, 32'h0);
    check("rst_irq", irq, 1'b0);
    read_check("rst_status", 4'd0, 32'h0);
    read_check("rst_rx_cnt", 4'd1, 32'h0);
    read_check("other_addr", 4'd4, 32'h0);

    // T1: bare command, no data, no response
    i0 = irq_count;
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h01);
    cpu_write(4'd0, ctrl(8'h01, 4'd0, 4'd0, 1'b0));
    wait_irq();
    tick(); tick();
    read_check("t1_status", 4'd0, 32'h4000_0000);
    check("t1_exp_empty", exp_q.size(), 0);
    check("t1_irq_pulses", irq_count - i0, 1);
    cpu_write(4'd1, 32'h0);
    read_check("clear_status", 4'd0, 32'h0);

    // T2: two data bytes, one response byte
    cpu_write(4'd8, 32'h1100_0000);
    cpu_write(4'd9, 32'h2200_0000);
    rsp_q.push_back(8'h51);
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h2B); push_w(3'd2, 8'h11);
    push_w(3'd2, 8'h22); push_w(3'd1, 8'h00);
    cpu_write(4'd0, ctrl(8'h2B, 4'd2, 4'd1, 1'b0));
    wait_irq();
    tick();
    read_check("t2_rxbuf0", 4'd8, 32'h5100_0000);
    read_check("t2_rx_cnt", 4'd1, 32'h0100_0000);
    read_check("t2_status", 4'd0, 32'h4000_0000);
    check("t2_exp_empty", exp_q.size(), 0);

    // T3: lengths of 15 saturate to 8 bytes each way
    for (int i = 0; i < 8; i++) cpu_write(4'(8 + i), {8'hA0 + 8'(i), 24'h0});
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h3A);
    for (int i = 0; i < 8; i++) push_w(3'd2, 8'hA0 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      rsp_q.push_back(8'hC0 + 8'(i));
      push_w(3'd1, 8'h00);
    end
    cpu_write(4'd0, ctrl(8'h3A, 4'd15, 4'd15, 1'b0));
    wait_irq();
    tick();
    read_check("t3_rx_cnt", 4'd1, 32'h0800_0000);
    read_check("t3_rxbuf0", 4'd8, 32'hC000_0000);
    read_check("t3_rxbuf7", 4'd15, 32'hC700_0000);
    read_check("t3_status", 4'd0, 32'h4000_0000);
    check("t3_exp_empty", exp_q.size(), 0);

    // T4: second response byte never arrives -> timeout
    rsp_q.push_back(8'h5A);
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h27); push_w(3'd1, 8'h00);
    i0 = irq_count;
    w0 = wr_count;
    cpu_write(4'd0, ctrl(8'h27, 4'd0, 4'd2, 1'b0));
    wait_writes(w0 + 3);          // now in the cycle of the first RX_ACK
    k = 0;
    do begin
      tick();
      k++;
    end while (!irq && k < 200);
    // RX_POLL is entered at k=1; FINISH is expected 64 cycles later.
    check("t4_timeout_cycles", k, 65);
    check("t4_finish_status", spo, 32'h6000_0000);
    tick(); tick();
    check("t4_irq_pulses", irq_count - i0, 1);
    read_check("t4_rx_cnt", 4'd1, 32'h0100_0000);
    read_check("t4_rxbuf0", 4'd8, 32'h5A00_0000);
    check("t4_exp_empty", exp_q.size(), 0);
    cpu_write(4'd1, 32'h0);
    read_check("t4_cleared", 4'd0, 32'h0);

    // T5: wait for nint before reading the response
    nint = 1'b1;
    rsp_q.push_back(8'hA5);
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h22); push_w(3'd1, 8'h00);
    w0 = wr_count;
    cpu_write(4'd0, ctrl(8'h22, 4'd0, 4'd1, 1'b1));
    wait_writes(w0 + 2);
    bad = 0;
    repeat (30) begin
      tick();
      if (m_a == 3'd1 && !m_we) bad++;
    end
    check("t5_no_rx_poll", bad, 0);
    check("t5_int_wait_m_a", m_a, 3'd3);
    nint = 1'b0;
    wait_irq();
    nint = 1'b1;
    tick();
    read_check("t5_rxbuf0", 4'd8, 32'hA500_0000);
    read_check("t5_status", 4'd0, 32'h4000_0000);
    check("t5_exp_empty", exp_q.size(), 0);

    // T6: CTRL and txbuf writes while busy are ignored
    cpu_write(4'd8, 32'h3300_0000);
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h3C); push_w(3'd2, 8'h33);
    cpu_write(4'd0, ctrl(8'h3C, 4'd1, 4'd0, 1'b1));
    cpu_write(4'd8, 32'hFF00_0000);
    cpu_write(4'd0, ctrl(8'h77, 4'd0, 4'd0, 1'b0));
    repeat (10) tick();
    nint = 1'b0;
    wait_irq();
    nint = 1'b1;
    tick();
    check("t6_exp_empty", exp_q.size(), 0);
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h01); push_w(3'd2, 8'h33);
    cpu_write(4'd0, ctrl(8'h01, 4'd1, 4'd0, 1'b0));
    wait_irq();
    tick();
    check("t6_txbuf_kept", exp_q.size(), 0);

    // T7: reset while polling the TX flag
    tx_stall = 1'b1;
    push_w(3'd1, 8'h00);
    cpu_write(4'd0, ctrl(8'h0A, 4'd0, 4'd0, 1'b0));
    tick(); tick();
    check("t7_in_tx_poll", m_a, 3'd2);
    check("t7_busy", spo, 32'h8000_0000);
    rst = 1'b1;
    tick();
    check("t7_rst_status", spo, 32'h0);
    check("t7_rst_m_we", m_we, 1'b0);
    check("t7_rst_m_a", m_a, 3'd2);
    check("t7_rst_m_d", m_d, 32'h0);
    rst = 1'b0;
    tx_stall = 1'b0;
    exp_q.delete();
    tick();
    rsp_q.push_back(8'h99);
    push_w(3'd1, 8'h00); push_w(3'd0, 8'h05); push_w(3'd1, 8'h00);
    cpu_write(4'd0, ctrl(8'h05, 4'd0, 4'd1, 1'b0));
    wait_irq();
    tick();
    read_check("t7_rxbuf0", 4'd8, 32'h9900_0000);
    read_check("t7_rx_cnt", 4'd1, 32'h0100_0000);
    read_check("t7_status", 4'd0, 32'h4000_0000);
    check("t7_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/ch375_seq.md
Name: ch375_seq

Overview:
- Hardware command sequencer in front of the ch375b serial driver.
- Runs one complete CH375 transaction with no CPU polling: a command byte, 0-8 data bytes, an optional wait for the chip's interrupt line, then 0-8 response bytes.
- It owns ch375b's register bus and exposes a small CPU-side register file with a done/error interrupt.

Parameters:
- TIMEOUT, 1000000, number of clk cycles allowed per wait (TX idle, INT, each RX byte) before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- a  in  4  CPU word address
- d  in  32  CPU write data; bytes are carried in d[31:24]
- we  in  1  CPU write strobe
- spo  out  32  CPU read data, combinational from a
- irq  out  1  one-cycle pulse when a transaction ends
- m_a  out  3  ch375b address
- m_d  out  32  ch375b write data; the byte is in m_d[31:24], other bits 0
- m_we  out  1  ch375b write strobe
- m_spo  in  32  ch375b combinational read data; flags are in bit 24

Behaviour:
- CPU register map:
  - a=0 write CTRL: cmd=d[31:24], tx_len=d[23:20], rx_len=d[19:16], wait_int=d[15].
  - a=0 read STATUS: {busy, done, err, 5'b0, 24'b0}.
  - a=1 write: clears done and err.
  - a=1 read: {rx_cnt[3:0] in [27:24], 24'b0}.
  - a=8..15 write: txbuf[a[2:0]] <= d[31:24].
  - a=8..15 read: {rxbuf[a[2:0]], 24'b0}.
  - Other addresses read 0.
- Length rules: tx_len and rx_len values 9-15 are treated as 8.
- Start: a CTRL write while IDLE latches the fields, clears done, err and rx_cnt, and sets busy the next cycle. CTRL and txbuf writes while busy are ignored. The a=1 clear is honoured at any time.
- FSM, one state per cycle unless it is waiting:
  - IDLE
  - CLR_RX: m_a=1, m_we=1, discards a stale rx_new.
  - TX_POLL: m_a=2; waits for m_spo[24]=1.
  - TX_WRITE: the first write uses m_a=0 with cmd; subsequent writes use m_a=2 with txbuf[i], i=0..tx_len-1.
  - SETTLE: m_we=0 for exactly one cycle after every write, so the ch375b busy flag is valid before the next poll.
  - TX_POLL repeats until all bytes are written, then goes to INT_WAIT if wait_int, else RX_POLL.
  - INT_WAIT: m_a=3; waits for m_spo[24]=0, i.e. nint low.
  - RX_POLL: m_a=1; waits for m_spo[24]=1. Skipped entirely if rx_len=0.
  - RX_READ: m_a=0; stores m_spo[31:24] into rxbuf[rx_cnt] and increments rx_cnt.
  - RX_ACK: m_a=1, m_we=1; then RX_POLL again until rx_cnt=rx_len.
  - FINISH: done=1, busy=0, irq=1 for one cycle, then IDLE.
- Timeout: one counter, cleared on entry to each waiting state (TX_POLL, INT_WAIT, RX_POLL). When it reaches TIMEOUT-1 without the condition being met, the FSM sets err=1 and goes to FINISH, so done=1 as well. rxbuf keeps the bytes already received and rx_cnt shows how many.
- m_we is high only in CLR_RX, TX_WRITE and RX_ACK. m_a holds its value in all other states; in IDLE m_a=2.
- The final transmitted byte is not awaited: the FSM moves to the next phase right after that byte's SETTLE.
- Reset (including mid-transaction): FSM to IDLE; busy, done, err, irq, m_we = 0; rx_cnt=0; m_a=2; m_d=0. txbuf and rxbuf contents are not reset.
- Simultaneous events: a CTRL write and an a=1 clear cannot coincide (single address). A CPU write landing in the same cycle as FINISH: the FINISH state updates take priority over the a=1 clear for that cycle.

Test Plan:
- Reset, then CTRL cmd=0x01 with tx_len=0, rx_len=0 → m_we pulses: a=1, then a=0 with m_d[31:24]=0x01; irq pulses once; STATUS=0x40000000.
- txbuf[0]=0x11, txbuf[1]=0x22; CTRL cmd=0x2B, tx_len=2, rx_len=1 against a ch375b model that returns 0x51 → writes in order 0x2B@a0, 0x11@a2, 0x22@a2, each followed by one idle cycle; rxbuf[0]=0x51; rx_cnt=1; done=1, err=0.
- TIMEOUT=64 with rx_len=2; the model returns only one byte → exactly 64 cycles after entering the second RX_POLL, err=1 and done=1; rx_cnt=1; one irq pulse.
- wait_int=1 with nint held high for 30 cycles → no RX_POLL access until nint falls; the transaction then completes normally.
- CTRL write and txbuf[0]=0xFF write while busy → both ignored: the latched command is unchanged and txbuf[0] keeps its old value.
- Assert rst during TX_POLL → the next cycle shows busy=0, m_we=0, m_a=2; a new CTRL write starts cleanly.
